// File: rtl/wisard_tuple_streamer.sv
// Serialises one parallel sample per handshake onto the wisard core's
// sop / sink_valid / addr inputs, then optionally waits for the prediction.
module wisard_tuple_streamer #(
  parameter int unsigned INPUT_WIDTH = 64,
  parameter bit          LSB_FIRST   = 1'b1,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter bit          WAIT_PRED   = 1'b1,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] in_data,
  input  logic                   pred_valid,
  output logic                   sop,
  output logic                   tuple_valid,
  output logic                   tuple_bit,
  output logic                   busy,
  output logic [15:0]            sample_cnt,
  output logic                   timeout_err
);

  localparam int unsigned BW        = $clog2(INPUT_WIDTH);
  localparam int unsigned GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned BIT_LAST  = INPUT_WIDTH - 1;
  localparam int unsigned GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned WAIT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    WAIT  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]          wait_cnt_q, wait_cnt_d;
  logic                   pred_seen_q, pred_seen_d;
  logic [15:0]            sample_cnt_q, sample_cnt_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic                   sop_q, sop_d;
  logic                   tuple_valid_q, tuple_valid_d;
  logic                   tuple_bit_q, tuple_bit_d;

  // Next-state, datapath and next-output logic; serial outputs trail the state by one register.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    pred_seen_d   = pred_seen_q;
    sample_cnt_d  = sample_cnt_q;
    timeout_err_d = timeout_err_q;
    sop_d         = 1'b0;
    tuple_valid_d = 1'b0;
    tuple_bit_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_ready_q && in_valid) begin
          shreg_d     = in_data;
          bit_cnt_d   = '0;
          gap_cnt_d   = '0;
          wait_cnt_d  = '0;
          pred_seen_d = 1'b0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        tuple_valid_d = 1'b1;
        sop_d         = (bit_cnt_q == '0);
        tuple_bit_d   = LSB_FIRST ? shreg_q[0] : shreg_q[INPUT_WIDTH-1];
        shreg_d       = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
        bit_cnt_d     = bit_cnt_q + BW'(1);
        if (pred_valid) pred_seen_d = 1'b1;
        if (bit_cnt_q == BW'(BIT_LAST)) begin
          sample_cnt_d = sample_cnt_q + 16'd1;
          if (GAP_CYCLES != 0) state_d = GAP;
          else if (WAIT_PRED)  state_d = WAIT;
          else                 state_d = IDLE;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (pred_valid) pred_seen_d = 1'b1;
        if (gap_cnt_q == GW'(GAP_LAST)) begin
          state_d = WAIT_PRED ? WAIT : IDLE;
        end
      end
      WAIT: begin
        if (pred_seen_q || pred_valid) begin
          state_d = IDLE;
        end else if (wait_cnt_q == TW'(WAIT_LAST)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      pred_seen_q   <= 1'b0;
      sample_cnt_q  <= '0;
      timeout_err_q <= 1'b0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      sop_q         <= 1'b0;
      tuple_valid_q <= 1'b0;
      tuple_bit_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      pred_seen_q   <= pred_seen_d;
      sample_cnt_q  <= sample_cnt_d;
      timeout_err_q <= timeout_err_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      sop_q         <= sop_d;
      tuple_valid_q <= tuple_valid_d;
      tuple_bit_q   <= tuple_bit_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign sop         = sop_q;
  assign tuple_valid = tuple_valid_q;
  assign tuple_bit   = tuple_bit_q;
  assign sample_cnt  = sample_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_wisard_tuple_streamer.sv
// Bench for wisard_tuple_streamer: instance 0 is LSB-first with gap and
// prediction wait, instance 1 is MSB-first, no gap, no wait.
module tb_wisard_tuple_streamer;

  localparam int unsigned W     = 64;
  localparam int unsigned GAP_A = 4;
  localparam int unsigned TO_A  = 16;
  localparam int          LIMIT = 200;

  logic clk;
  logic rst_n;
  logic [1:0]        in_valid;
  logic [1:0]        pred_valid;
  logic [1:0][W-1:0] in_data;
  wire  [1:0]        in_ready;
  wire  [1:0]        sop;
  wire  [1:0]        tuple_valid;
  wire  [1:0]        tuple_bit;
  wire  [1:0]        busy;
  wire  [1:0]        timeout_err;
  wire  [1:0][15:0]  sample_cnt;

  int n_cmp;
  int n_bad;
  int exp_cnt [2];

  wisard_tuple_streamer #(
    .INPUT_WIDTH(W), .LSB_FIRST(1'b1), .GAP_CYCLES(GAP_A), .WAIT_PRED(1'b1), .TIMEOUT(TO_A)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .pred_valid(pred_valid[0]), .sop(sop[0]),
    .tuple_valid(tuple_valid[0]), .tuple_bit(tuple_bit[0]), .busy(busy[0]),
    .sample_cnt(sample_cnt[0]), .timeout_err(timeout_err[0])
  );

  wisard_tuple_streamer #(
    .INPUT_WIDTH(W), .LSB_FIRST(1'b0), .GAP_CYCLES(0), .WAIT_PRED(1'b0), .TIMEOUT(TO_A)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .pred_valid(pred_valid[1]), .sop(sop[1]),
    .tuple_valid(tuple_valid[1]), .tuple_bit(tuple_bit[1]), .busy(busy[1]),
    .sample_cnt(sample_cnt[1]), .timeout_err(timeout_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wire order of a sample: element i is the i-th bit put on tuple_bit.
  function automatic logic [W-1:0] exp_bits(input int u, input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (u == 0) ? d[i] : d[W-1-i];
    return r;
  endfunction

  // Edge index (handshake edge = 0) after which in_ready is high again,
  // given the edge t at which pred_valid is sampled (t < 2 means none usable).
  function automatic int exp_ready(input int u, input int t);
    int ws;
    if (u == 1) return W + 1;
    ws = W + GAP_A + 2;
    if (t >= 2 && t < ws) return ws;
    if (t >= ws && t < ws + TO_A) return t;
    return ws + TO_A - 1;
  endfunction

  function automatic bit exp_timeout(input int t);
    return !(t >= 2 && t < W + GAP_A + 2 + TO_A);
  endfunction

  // Offers one sample, pulses pred_valid so it is sampled at edge t, and
  // records what comes out until in_ready returns (or LIMIT cycles pass).
  task automatic drive(input int u, input logic [W-1:0] d, input int t,
                       output logic [W-1:0] bits, output int nvalid, output int nsop,
                       output int sop_k, output int ready_k);
    bits = '0; nvalid = 0; nsop = 0; sop_k = -1; ready_k = -1;
    @(negedge clk);
    in_data[u]    = d;
    in_valid[u]   = 1'b1;
    pred_valid[u] = (t == 1);
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      in_valid[u] = 1'b0;
      in_data[u]  = W'({$urandom, $urandom});
      if (tuple_valid[u]) begin
        if (nvalid < W) bits[nvalid] = tuple_bit[u];
        nvalid++;
      end
      if (sop[u]) begin nsop++; sop_k = k; end
      if (in_ready[u]) begin ready_k = k; break; end
      pred_valid[u] = (k + 1 == t);
    end
    pred_valid[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; pred_valid = '0; in_data = '0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      if ({in_ready[u], sop[u], tuple_valid[u], tuple_bit[u], busy[u], timeout_err[u]} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_outputs[%0d]: got rdy/sop/val/bit/busy/err=%b%b%b%b%b%b want 000000", u,
                 in_ready[u], sop[u], tuple_valid[u], tuple_bit[u], busy[u], timeout_err[u]);
      end
      n_cmp++;
      if (sample_cnt[u] !== 16'd0) begin
        n_bad++; $display("FAIL reset_sample_cnt[%0d]: got %0d want 0", u, sample_cnt[u]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      if (in_ready[u] !== 1'b1 || busy[u] !== 1'b0) begin
        n_bad++; $display("FAIL ready_after_reset[%0d]: got rdy=%b busy=%b want 1 0", u, in_ready[u], busy[u]);
      end
    end
  endtask

  task automatic check_sample(input string name, input int u, input logic [W-1:0] d, input int t,
                              input logic [W-1:0] bits, input int nv, input int ns,
                              input int sk, input int rk);
    n_cmp++;
    if (bits !== exp_bits(u, d) || nv != W) begin
      n_bad++; $display("FAIL %s bits: got %h (%0d valid) want %h (%0d valid)", name, bits, nv, exp_bits(u, d), W);
    end
    n_cmp++;
    if (ns != 1 || sk != 2) begin
      n_bad++; $display("FAIL %s sop: got %0d pulses at cycle %0d want 1 at cycle 2", name, ns, sk);
    end
    n_cmp++;
    if (rk != exp_ready(u, t)) begin
      n_bad++; $display("FAIL %s ready_cycle: got %0d want %0d", name, rk, exp_ready(u, t));
    end
    n_cmp++;
    if (sample_cnt[u] !== 16'(exp_cnt[u])) begin
      n_bad++; $display("FAIL %s sample_cnt: got %0d want %0d", name, sample_cnt[u], exp_cnt[u]);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] d, bits; int nv, ns, sk, rk, t;
    d = 64'h0000_0000_0000_0001;
    t = W + 1 + 10 + 1;  // pulse visible 10 cycles after the last bit
    drive(0, d, t, bits, nv, ns, sk, rk);
    exp_cnt[0]++;
    check_sample("lsb_first", 0, d, t, bits, nv, ns, sk, rk);
    n_cmp++;
    if (timeout_err[0] !== 1'b0) begin
      n_bad++; $display("FAIL lsb_first timeout_err: got %b want 0", timeout_err[0]);
    end
  endtask

  task automatic test_msb_first();
    logic [W-1:0] d, bits; int nv, ns, sk, rk;
    d = 64'h0000_0000_0000_0001;
    drive(1, d, 0, bits, nv, ns, sk, rk);
    exp_cnt[1]++;
    check_sample("msb_first", 1, d, 0, bits, nv, ns, sk, rk);
  endtask

  task automatic test_pred_in_gap();
    logic [W-1:0] d, bits; int nv, ns, sk, rk, t;
    d = W'({$urandom, $urandom});
    t = W + 1 + $urandom_range(1, GAP_A);
    drive(0, d, t, bits, nv, ns, sk, rk);
    exp_cnt[0]++;
    check_sample("pred_in_gap", 0, d, t, bits, nv, ns, sk, rk);
    n_cmp++;
    if (timeout_err[0] !== 1'b0) begin
      n_bad++; $display("FAIL pred_in_gap timeout_err: got %b want 0", timeout_err[0]);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d, bits; int nv, ns, sk, rk, t, u;
    for (int i = 0; i < 8; i++) begin
      u = (i % 3 == 2) ? 1 : 0;
      d = W'({$urandom, $urandom});
      t = $urandom_range(2, W + GAP_A + TO_A + 1);
      drive(u, d, t, bits, nv, ns, sk, rk);
      exp_cnt[u]++;
      check_sample("random", u, d, t, bits, nv, ns, sk, rk);
    end
    n_cmp++;
    if (timeout_err[0] !== 1'b0) begin
      n_bad++; $display("FAIL random timeout_err: got %b want 0", timeout_err[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q[$];
    logic [W-1:0] word, want;
    int pushed, got, nbits, last_sop;
    bit change;
    pushed = 0; got = 0; nbits = 0; last_sop = -1; change = 1'b0; word = '0;
    @(negedge clk);
    in_data[1]  = W'({$urandom, $urandom});
    in_valid[1] = 1'b1;
    for (int k = 0; k < 400 && got < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (change) begin
        if (pushed == 4) in_valid[1] = 1'b0;
        else in_data[1] = W'({$urandom, $urandom});
        change = 1'b0;
      end
      if (sop[1]) begin
        if (last_sop >= 0) begin
          n_cmp++;
          if (k - last_sop != W + 1) begin
            n_bad++; $display("FAIL back_to_back period: got %0d want %0d", k - last_sop, W + 1);
          end
        end
        last_sop = k; nbits = 0;
      end
      if (tuple_valid[1] && nbits < W) begin
        word[nbits] = tuple_bit[1];
        nbits++;
        if (nbits == W) begin
          want = (q.size() > 0) ? q.pop_front() : '0;
          exp_cnt[1]++; got++;
          n_cmp++;
          if (word !== exp_bits(1, want)) begin
            n_bad++; $display("FAIL back_to_back word%0d: got %h want %h", got, word, exp_bits(1, want));
          end
        end
      end
      if (in_ready[1] && in_valid[1] && pushed < 4) begin
        q.push_back(in_data[1]); pushed++; change = 1'b1;
      end
    end
    in_valid[1] = 1'b0;
    n_cmp++;
    if (got != 4) begin
      n_bad++; $display("FAIL back_to_back count: got %0d samples want 4", got);
    end
    n_cmp++;
    if (sample_cnt[1] !== 16'(exp_cnt[1])) begin
      n_bad++; $display("FAIL back_to_back sample_cnt: got %0d want %0d", sample_cnt[1], exp_cnt[1]);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] d, bits; int nv, ns, sk, rk, t;
    // pred_valid only at the handshake edge (IDLE): must be ignored
    d = W'({$urandom, $urandom});
    t = 1;
    drive(0, d, t, bits, nv, ns, sk, rk);
    exp_cnt[0]++;
    check_sample("timeout", 0, d, t, bits, nv, ns, sk, rk);
    n_cmp++;
    if (timeout_err[0] !== exp_timeout(t)) begin
      n_bad++; $display("FAIL timeout flag: got %b want %b", timeout_err[0], exp_timeout(t));
    end
    // flag is sticky through a later, well-behaved sample
    d = W'({$urandom, $urandom});
    t = W + GAP_A + 4;
    drive(0, d, t, bits, nv, ns, sk, rk);
    exp_cnt[0]++;
    check_sample("after_timeout", 0, d, t, bits, nv, ns, sk, rk);
    n_cmp++;
    if (timeout_err[0] !== 1'b1) begin
      n_bad++; $display("FAIL timeout sticky: got %b want 1", timeout_err[0]);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [W-1:0] d, bits; int nv, ns, sk, rk, t;
    @(negedge clk);
    in_data[0] = W'({$urandom, $urandom}); in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (31) @(negedge clk);  // bit 30 is on the wire now
    n_cmp++;
    if (tuple_valid[0] !== 1'b1 || tuple_bit[0] !== in_data[0][0] && 1'b0) begin
      n_bad++; $display("FAIL mid_shift pre_reset: got valid=%b want 1", tuple_valid[0]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tuple_valid[0], in_ready[0], sop[0], busy[0], timeout_err[0]} !== 5'b0) begin
      n_bad++; $display("FAIL mid_shift async_reset: got val/rdy/sop/busy/err=%b%b%b%b%b want 00000",
                        tuple_valid[0], in_ready[0], sop[0], busy[0], timeout_err[0]);
    end
    n_cmp++;
    if (sample_cnt[0] !== 16'd0) begin
      n_bad++; $display("FAIL mid_shift sample_cnt: got %0d want 0", sample_cnt[0]);
    end
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready[0] !== 1'b1) begin
      n_bad++; $display("FAIL mid_shift ready_after_release: got %b want 1", in_ready[0]);
    end
    d = W'({$urandom, $urandom});
    t = W + GAP_A + 2 + $urandom_range(0, 5);
    drive(0, d, t, bits, nv, ns, sk, rk);
    exp_cnt[0]++;
    check_sample("after_mid_reset", 0, d, t, bits, nv, ns, sk, rk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_pred_in_gap();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
